led_seq_ctrl: RTL and testbench

Programmable LED pattern sequencer that schedules the board's blink output. It replaces the free-running fixed-rate toggle with a table-driven sequence of (level, duration) steps. A shared tick prescaler times every step. It sits between the control/config logic (a register interface or button debouncer) and the LED pin, and drives the same active-high `opt` output.

---
 rtl/led_seq_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 29 ++
 rtl/led_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_led_seq_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and default constants for the LED pattern sequencer.
// The optional LED_SEQ_LOOP_EN macro is consumed by led_seq_ctrl.
package led_seq_pkg;

    localparam int DEF_TICK_DIV = 5000000;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_DUR_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic                 level;
        logic [DEF_DUR_W-1:0] dur;
    } step_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick generator: one-cycle pulse every TICK_DIV enabled cycles.
// clr zeroes the count so a new pattern never starts with a partial tick.
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic res,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (res || clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Table-driven LED blink sequencer: plays (level, duration) steps timed by a shared tick.
// Define LED_SEQ_LOOP_EN to honour the loop input; otherwise every pattern runs once.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int DUR_W    = DEF_DUR_W
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
    input  logic                       cfg_level,
    input  logic [DUR_W-1:0]           cfg_dur,
    input  logic [$clog2(DEPTH):0]     cfg_len,
    input  logic                       loop,
    input  logic                       start,
    input  logic                       stop,
    output logic                       opt,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

    // Pattern table; contents survive reset.
    logic             tbl_level [DEPTH];
    logic [DUR_W-1:0] tbl_dur   [DEPTH];

    always_ff @(posedge clk) begin
        if (cfg_we) begin
            tbl_level[cfg_addr] <= cfg_level;
            tbl_dur[cfg_addr]   <= cfg_dur;
        end
    end

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [LW-1:0]     len_q, len_d;
    logic [DUR_W-1:0]  rem_q, rem_d;
    logic              level_q, level_d;
    logic              pre_clr;
    logic              tick;
    logic [LW-1:0]     idx_inc;
    logic [AW-1:0]     nxt_idx;
    logic              last;

`ifdef LED_SEQ_LOOP_EN
    logic loop_q, loop_d;
`else
    logic unused_loop;
    assign unused_loop = loop;
`endif

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk  (clk),
        .res  (res),
        .clr  (pre_clr),
        .en   (state_q == RUN),
        .tick (tick)
    );

    assign idx_inc = {1'b0, idx_q} + LW'(1);
    assign nxt_idx = idx_inc[AW-1:0];
    assign last    = (idx_inc == len_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        rem_d   = rem_q;
        level_d = level_q;
        pre_clr = 1'b0;
`ifdef LED_SEQ_LOOP_EN
        loop_d  = loop_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !stop && (cfg_len != '0)) begin
                    state_d = RUN;
                    idx_d   = '0;
                    rem_d   = tbl_dur[0];
                    level_d = tbl_level[0];
                    len_d   = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
                    pre_clr = 1'b1;
`ifdef LED_SEQ_LOOP_EN
                    loop_d  = loop;
`endif
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    pre_clr = 1'b1;
                end else if (tick) begin
                    // A loaded duration of 0 wraps to all-ones, giving 2^DUR_W ticks.
                    if (rem_q == DUR_W'(1)) begin
                        if (!last) begin
                            idx_d   = nxt_idx;
                            rem_d   = tbl_dur[nxt_idx];
                            level_d = tbl_level[nxt_idx];
                        end
`ifdef LED_SEQ_LOOP_EN
                        else if (loop_q) begin
                            idx_d   = '0;
                            rem_d   = tbl_dur[0];
                            level_d = tbl_level[0];
                        end
`endif
                        else begin
                            state_d = DONE;
                        end
                    end else begin
                        rem_d = rem_q - DUR_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            level_q <= 1'b0;
`ifdef LED_SEQ_LOOP_EN
            loop_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            level_q <= level_d;
`ifdef LED_SEQ_LOOP_EN
            loop_q  <= loop_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign opt  = (state_q == RUN) ? level_q : 1'b1;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed scenarios plus random patterns against a cycle-schedule model.
// The model expands each accepted pattern into the per-cycle {opt,busy,done} sequence it must produce.
module tb_led_seq_ctrl;
    import led_seq_pkg::*;

    localparam int TD    = 4;
    localparam int DEPTH = 8;
    localparam int DUR_W = 8;
    localparam logic [2:0] O_IDLE = 3'b100;
    localparam logic [2:0] O_DONE = 3'b101;
`ifdef LED_SEQ_LOOP_EN
    localparam bit LOOP_ON = 1'b1;
`else
    localparam bit LOOP_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             res = 1'b1;
    logic             cfg_we = 1'b0;
    logic [2:0]       cfg_addr = '0;
    logic             cfg_level = 1'b0;
    logic [DUR_W-1:0] cfg_dur = '0;
    logic [3:0]       cfg_len = '0;
    logic             loop = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             opt, busy, done;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    led_seq_ctrl #(.TICK_DIV(TD), .DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
        .clk       (clk),
        .res       (res),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_level (cfg_level),
        .cfg_dur   (cfg_dur),
        .cfg_len   (cfg_len),
        .loop      (loop),
        .start     (start),
        .stop      (stop),
        .opt       (opt),
        .busy      (busy),
        .done      (done)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: table image plus a queue of upcoming {opt,busy,done} values
    step_t      m_tbl [DEPTH];
    logic [2:0] exp_q [$];
    logic [2:0] m_cur = O_IDLE;
    int         m_len = 0;
    bit         m_loop = 1'b0;

    task automatic expand();
        for (int i = 0; i < m_len; i++) begin
            int d;
            d = (m_tbl[i].dur == 0) ? 256 : int'(m_tbl[i].dur);
            repeat (d * TD) exp_q.push_back({m_tbl[i].level, 2'b10});
        end
        if (!m_loop) exp_q.push_back(O_DONE);
    endtask

    always @(posedge clk) begin
        if (cfg_we) m_tbl[cfg_addr] <= '{level: cfg_level, dur: cfg_dur};
        if (res) begin
            exp_q.delete();
            m_cur  = O_IDLE;
            m_loop = 1'b0;
            chk_en = 1'b1;
        end else if (m_cur[1] && stop) begin
            exp_q.delete();
            m_cur = O_IDLE;
        end else if (m_cur == O_IDLE && start && !stop && cfg_len != 0) begin
            m_len  = (int'(cfg_len) > DEPTH) ? DEPTH : int'(cfg_len);
            m_loop = LOOP_ON && loop;
            exp_q.delete();
            expand();
            m_cur = exp_q.pop_front();
        end else begin
            if (exp_q.size() == 0 && m_cur[1] && m_loop) expand();
            m_cur = (exp_q.size() != 0) ? exp_q.pop_front() : O_IDLE;
        end
    end

    task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got {opt,busy,done}=%b expected %b", tag, $time, got, exp);
        end
    endtask

    // scoreboard: compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) check_eq("outs", {opt, busy, done}, m_cur);
    end

    // driver tasks
    task automatic wr(input int a, input logic lv, input int d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_level = lv; cfg_dur = DUR_W'(d);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse(input bit s, input bit p);
        @(negedge clk);
        start = s; stop = p;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        res = 1'b1;
        idle(3);
        res = 1'b0;
        idle(20);

        // one-shot two-step pattern
        wr(0, 1'b0, 2);
        wr(1, 1'b1, 3);
        cfg_len = 4'd2; loop = 1'b0;
        pulse(1'b1, 1'b0);
        idle(30);

        // looping pattern, three periods, then abort
        loop = 1'b1;
        pulse(1'b1, 1'b0);
        idle(60);
        pulse(1'b0, 1'b1);
        idle(5);

        // zero duration means 256 ticks
        loop = 1'b0;
        wr(0, 1'b0, 0);
        cfg_len = 4'd1;
        pulse(1'b1, 1'b0);
        idle(1030);

        // start+stop together, then zero length
        wr(0, 1'b0, 2);
        cfg_len = 4'd2;
        pulse(1'b1, 1'b1);
        idle(5);
        cfg_len = 4'd0;
        pulse(1'b1, 1'b0);
        idle(5);

        // reset in the middle of a run
        cfg_len = 4'd2;
        pulse(1'b1, 1'b0);
        idle(6);
        @(negedge clk); res = 1'b1;
        @(negedge clk); res = 1'b0;
        idle(5);

        // randomized patterns, lengths beyond the table, stray start/stop
        for (int it = 0; it < 25; it++) begin
            for (int a = 0; a < DEPTH; a++)
                wr(a, 1'($urandom_range(0, 1)), $urandom_range(1, 5));
            cfg_len = 4'($urandom_range(0, 15));
            loop    = 1'($urandom_range(0, 1));
            pulse(1'b1, 1'($urandom_range(0, 9) == 0));
            idle($urandom_range(5, 80));
            if ($urandom_range(0, 3) == 0) pulse(1'b1, 1'b0);
            idle($urandom_range(0, 120));
            pulse(1'b0, 1'b1);
            idle(3);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
